jtframe_dwnld_pack: RTL
=======================

# jtframe_dwnld_pack

Packs the byte stream coming out of the MiSTer download unpacker (`ioctl_addr`, `ioctl_dout`, `ioctl_rom_wr`) into 16-bit SDRAM programming words with bank selection and byte masks. It drives the `prog_*` port of the frame's board/SDRAM stage and produces the `dwnld_busy` flag that keeps the game in reset until the last word is committed. Back-pressure towards the download path is provided through `dwnld_wait`.

## Interface
Parameters:
- `BA1_START`, default 27'h7FF_FFFF: first byte address mapped to bank 1.
- `BA2_START`, default 27'h7FF_FFFF: first byte address mapped to bank 2.
- `BA3_START`, default 27'h7FF_FFFF: first byte address mapped to bank 3.
- Constraint: BA1_START ≤ BA2_START ≤ BA3_START, all even.

Ports:
- `clk` in 1: ROM-domain clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `downloading` in 1: download session active.
- `ioctl_addr` in 27: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_rom_wr` in 1: one-cycle byte strobe.
- `dwnld_wait` out 1: upstream must not strobe while high.
- `dwnld_busy` out 1: `downloading` OR any byte/word pending.
- `prog_addr` out 22: word address within the bank.
- `prog_data` out 16: word data.
- `prog_mask` out 2: DQM style, 1 = byte not written; [0] low byte, [1] high byte.
- `prog_ba` out 2: SDRAM bank.
- `prog_we` out 1: write request, level.
- `prog_rdy` in 1: one-cycle completion pulse from SDRAM controller.
- `pack_err` out 1: sticky, strobe received while `dwnld_wait` was high.

## Operation
- Bank decode on each accepted byte: addr ≥ BA3_START → 3; else ≥ BA2_START → 2; else ≥ BA1_START → 1; else 0. Offset = addr − bank start. Word address = offset[22:1], truncated to 22 bits.
- Byte lane: offset[0]=0 → `prog_data[7:0]`; offset[0]=1 → `[15:8]`.
- Hold register: one partial word (data, word address, bank, 2 valid bits).
- States:
  - IDLE: hold empty, no write.
  - HOLD: hold partially filled.
  - WRITE: `prog_we` high, waiting for `prog_rdy`.
- IDLE + byte: load hold, go to HOLD.
- HOLD + byte with the same bank/word and the opposite lane: complete the word, issue it with mask 2'b00, go to WRITE; hold becomes empty.
- HOLD + byte with a different word/bank, or the same lane again: issue the held partial word (unwritten lane masked = 1), go to WRITE. The new byte is loaded into the now-empty hold.
- WRITE: one new byte may be loaded into an empty hold. `dwnld_wait` is high while in WRITE with a non-empty hold.
- WRITE + `prog_rdy`:
  - Go to HOLD if the hold is non-empty.
  - Otherwise go to IDLE.
- Falling edge of `downloading` with HOLD: flush the partial word (→ WRITE).
- A strobe while `dwnld_wait` is high is dropped and sets `pack_err`. `pack_err` clears only on reset.
- Strobes are ignored when `downloading` is low.

## Timing
- Reset values:
  - `prog_we`=0, `prog_addr`=0, `prog_data`=0, `prog_mask`=2'b11, `prog_ba`=0.
  - `dwnld_wait`=0, `pack_err`=0; state IDLE, hold empty.
  - `dwnld_busy` follows `downloading` combinationally.
- All `prog_*` outputs are registered and stable while `prog_we`=1.
- Completing byte strobe at cycle N → `prog_we`=1 at N+1.
- `prog_rdy` at cycle M → `prog_we`=0 at M+1. If a word is ready, the next `prog_we` rises at M+2 at the earliest, so there is at least one low cycle between writes.
- `dwnld_wait` is registered: asserted the cycle after the hold fills during WRITE, deasserted the cycle after `prog_rdy`.
- `prog_rdy` outside WRITE is ignored.
- Simultaneous strobe and `prog_rdy` in WRITE:
  - Both are taken.
  - The byte goes to the hold.
  - The state transition uses the post-load hold.
- Reset mid-write drops the pending word; `prog_we` falls asynchronously.

## Configuration
- `JTFRAME_DWNLD_SWAB_EN` defined: the byte lane is inverted (offset[0]=0 → `[15:8]`) for big-endian 16-bit ROM sets, and the masks follow the swapped lanes.
- Undefined: little-endian mapping as above.

## Test plan
- Bytes 0x11@0, 0x22@1, BA* default → one write: `prog_addr`=0, `prog_data`=16'h2211, `prog_mask`=00, `prog_ba`=0; `prog_we` rises the cycle after the second strobe.
- BA1_START=27'h100000, byte 0xAA@27'h100005, then `downloading` falls → `prog_ba`=1, `prog_addr`=2, `prog_data[15:8]`=AA, `prog_mask`=01; `dwnld_busy` stays high until `prog_rdy`.
- Bytes @4, then @9 → partial write @2 (mask 10), then a held byte @4 with the high lane valid; flushed at end with mask 01.
- `prog_rdy` delayed 10 cycles, three strobes back-to-back → `dwnld_wait` high after the second; third strobe dropped; `pack_err`=1.
- Assert `rst_n` low while `prog_we`=1 → `prog_we`=0 immediately; next session starts in IDLE.
- `JTFRAME_DWNLD_SWAB_EN`, 0x11@0, 0x22@1 → `prog_data`=16'h1122.

Source files
------------

// File: rtl/jtframe_dwnld_pack.sv
// jtframe_dwnld_pack
// Packs the download byte stream into 16-bit SDRAM programming words.
// Each word is tagged with an SDRAM bank and a DQM-style byte mask.
// Optional macro JTFRAME_DWNLD_SWAB_EN swaps the byte lanes for
// big-endian 16-bit ROM sets.
`timescale 1ns/1ps

module jtframe_dwnld_pack #(
   parameter logic [26:0] BA1_START = 27'h7FF_FFFF,
   parameter logic [26:0] BA2_START = 27'h7FF_FFFF,
   parameter logic [26:0] BA3_START = 27'h7FF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        downloading,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        ioctl_rom_wr,
   output logic        dwnld_wait,
   output logic        dwnld_busy,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        pack_err
);

`ifdef JTFRAME_DWNLD_SWAB_EN
   localparam logic SWAB = 1'b1;
`else
   localparam logic SWAB = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, HOLD, WRITE} state_t;

   state_t      state_q, state_d;
   logic [15:0] holdData_q, holdData_d;
   logic [21:0] holdAddr_q, holdAddr_d;
   logic [1:0]  holdBa_q, holdBa_d;
   logic [1:0]  holdValid_q, holdValid_d;
   logic [21:0] progAddr_q, progAddr_d;
   logic [15:0] progData_q, progData_d;
   logic [1:0]  progMask_q, progMask_d;
   logic [1:0]  progBa_q, progBa_d;
   logic        progWe_q, progWe_d;
   logic        wait_q, wait_d;
   logic        err_q, err_d;

   logic [1:0]  byteBa;
   logic [26:0] byteOffset;
   logic [21:0] byteWord;
   logic        byteLane;
   logic [15:0] byteData;
   logic [1:0]  byteValid;
   logic        strobe;
   logic        accept;
   logic        sameWord;
   logic        unusedOffsetBits;

   // Bank decode and lane placement for the incoming byte
   always_comb begin
      byteBa     = 2'd0;
      byteOffset = ioctl_addr;
      if (ioctl_addr >= BA3_START) begin
         byteBa     = 2'd3;
         byteOffset = ioctl_addr - BA3_START;
      end else if (ioctl_addr >= BA2_START) begin
         byteBa     = 2'd2;
         byteOffset = ioctl_addr - BA2_START;
      end else if (ioctl_addr >= BA1_START) begin
         byteBa     = 2'd1;
         byteOffset = ioctl_addr - BA1_START;
      end
      byteWord  = byteOffset[22:1];
      byteLane  = byteOffset[0] ^ SWAB;
      byteData  = byteLane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
      byteValid = byteLane ? 2'b10 : 2'b01;
   end

   assign unusedOffsetBits = ^byteOffset[26:23];

   assign strobe   = ioctl_rom_wr & downloading;
   assign accept   = strobe & ~wait_q;
   assign sameWord = (holdValid_q != 2'b00) && (holdBa_q == byteBa) &&
                     (holdAddr_q == byteWord) && ((holdValid_q & byteValid) == 2'b00);

   // Next-state logic: hold register management and word issue
   always_comb begin
      state_d     = state_q;
      holdData_d  = holdData_q;
      holdAddr_d  = holdAddr_q;
      holdBa_d    = holdBa_q;
      holdValid_d = holdValid_q;
      progAddr_d  = progAddr_q;
      progData_d  = progData_q;
      progMask_d  = progMask_q;
      progBa_d    = progBa_q;
      progWe_d    = progWe_q;
      err_d       = err_q | (strobe & wait_q);
      case (state_q)
         IDLE: begin
            if (accept) begin
               holdData_d  = byteData;
               holdAddr_d  = byteWord;
               holdBa_d    = byteBa;
               holdValid_d = byteValid;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (accept) begin
               progAddr_d = holdAddr_q;
               progBa_d   = holdBa_q;
               progWe_d   = 1'b1;
               state_d    = WRITE;
               if (sameWord) begin
                  progData_d  = holdData_q | byteData;
                  progMask_d  = 2'b00;
                  holdValid_d = 2'b00;
               end else begin
                  progData_d  = holdData_q;
                  progMask_d  = ~holdValid_q;
                  holdData_d  = byteData;
                  holdAddr_d  = byteWord;
                  holdBa_d    = byteBa;
                  holdValid_d = byteValid;
               end
            end else if (!downloading) begin
               progAddr_d  = holdAddr_q;
               progBa_d    = holdBa_q;
               progData_d  = holdData_q;
               progMask_d  = ~holdValid_q;
               progWe_d    = 1'b1;
               holdValid_d = 2'b00;
               state_d     = WRITE;
            end
         end
         WRITE: begin
            if (accept) begin
               if (holdValid_q == 2'b00) begin
                  holdData_d  = byteData;
                  holdAddr_d  = byteWord;
                  holdBa_d    = byteBa;
                  holdValid_d = byteValid;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (prog_rdy) begin
               progWe_d = 1'b0;
               state_d  = (holdValid_d != 2'b00) ? HOLD : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      wait_d = (state_d == WRITE) && (holdValid_d != 2'b00);
   end

   // State, hold and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         holdData_q  <= 16'h0000;
         holdAddr_q  <= 22'd0;
         holdBa_q    <= 2'd0;
         holdValid_q <= 2'b00;
         progAddr_q  <= 22'd0;
         progData_q  <= 16'h0000;
         progMask_q  <= 2'b11;
         progBa_q    <= 2'd0;
         progWe_q    <= 1'b0;
         wait_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         holdData_q  <= holdData_d;
         holdAddr_q  <= holdAddr_d;
         holdBa_q    <= holdBa_d;
         holdValid_q <= holdValid_d;
         progAddr_q  <= progAddr_d;
         progData_q  <= progData_d;
         progMask_q  <= progMask_d;
         progBa_q    <= progBa_d;
         progWe_q    <= progWe_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
      end
   end

   assign dwnld_busy = downloading | (state_q != IDLE);
   assign dwnld_wait = wait_q;
   assign prog_addr  = progAddr_q;
   assign prog_data  = progData_q;
   assign prog_mask  = progMask_q;
   assign prog_ba    = progBa_q;
   assign prog_we    = progWe_q;
   assign pack_err   = err_q;

endmodule
